// File: rtl/mem_stage_if.sv
// Data-memory bus between mem_stage (master) and the data memory (slave).
// req is held until ack; rdata is valid in the ack cycle.
interface mem_stage_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, we, addr, sel, wdata, input ack, rdata);
    modport slave  (input req, we, addr, sel, wdata, output ack, rdata);
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues loads/stores over a req/ack bus, stalls while busy, registers WB fields.
// Optional alignment trap enabled by defining MEM_ALIGN_CHECK_EN.
module mem_stage (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [4:0]   mem_wd_i,
    input  logic         mem_wreg_i,
    input  logic [31:0]  mem_wdata_i,
    input  logic [7:0]   mem_aluop_i,
    input  logic [31:0]  mem_mem_addr_i,
    input  logic [31:0]  mem_reg2_i,
    input  logic [31:0]  mem_pc_i,
    mem_stage_if.master  dm,
    output logic         stall_req_o,
    output logic [4:0]   wb_wd_o,
    output logic         wb_wreg_o,
    output logic [31:0]  wb_wdata_o,
    output logic [31:0]  wb_pc_o,
    output logic         misalign_exc_o,
    output logic [31:0]  badvaddr_o
);

    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_mem_op(input logic [7:0] op);
        case (op)
            EXE_LB_OP, EXE_LH_OP, EXE_LW_OP, EXE_LBU_OP, EXE_LHU_OP,
            EXE_SB_OP, EXE_SH_OP, EXE_SW_OP: is_mem_op = 1'b1;
            default:                          is_mem_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        case (op)
            EXE_SB_OP, EXE_SH_OP, EXE_SW_OP: is_store = 1'b1;
            default:                          is_store = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lane_sel(input logic [7:0] op, input logic [1:0] lo);
        case (op)
            EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: lane_sel = 4'b0001 << lo;
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: lane_sel = lo[1] ? 4'b1100 : 4'b0011;
            EXE_LW_OP, EXE_SW_OP:             lane_sel = 4'b1111;
            default:                          lane_sel = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [7:0] op, input logic [31:0] reg2);
        case (op)
            EXE_SB_OP: store_data = {4{reg2[7:0]}};
            EXE_SH_OP: store_data = {2{reg2[15:0]}};
            default:   store_data = reg2;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [7:0]  op,
                                                 input logic [1:0]  lo,
                                                 input logic [31:0] rdata);
        logic [31:0] shifted;
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        shifted = rdata >> {lo, 3'b000};
        byte_v  = shifted[7:0];
        half_v  = lo[1] ? rdata[31:16] : rdata[15:0];
        case (op)
            EXE_LB_OP:  load_extract = {{24{byte_v[7]}}, byte_v};
            EXE_LBU_OP: load_extract = {24'h000000, byte_v};
            EXE_LH_OP:  load_extract = {{16{half_v[15]}}, half_v};
            EXE_LHU_OP: load_extract = {16'h0000, half_v};
            default:    load_extract = rdata;
        endcase
    endfunction

`ifdef MEM_ALIGN_CHECK_EN
    function automatic logic misaligned(input logic [7:0] op, input logic [1:0] lo);
        case (op)
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: misaligned = lo[0];
            EXE_LW_OP, EXE_SW_OP:             misaligned = (lo != 2'b00);
            default:                          misaligned = 1'b0;
        endcase
    endfunction
`endif

    state_t      state_q, state_d;
    logic        mem_op_s;
    logic        fault_s;
    logic        issue_s;
    logic        stall_req_s;

    logic        req_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [3:0]  sel_q;
    logic [31:0] wdata_q;
    logic [7:0]  op_q;
    logic [1:0]  lo_q;
    logic [31:0] load_q;

    logic [4:0]  wb_wd_q;
    logic        wb_wreg_q;
    logic [31:0] wb_wdata_q;
    logic [31:0] wb_pc_q;

    assign mem_op_s = is_mem_op(mem_aluop_i);

`ifdef MEM_ALIGN_CHECK_EN
    assign fault_s = misaligned(mem_aluop_i, mem_mem_addr_i[1:0]);
`else
    assign fault_s = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = issue_s ? ST_REQ : ST_IDLE;
            ST_REQ:  state_d = dm.ack ? ST_DONE : ST_REQ;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: stall covers the issuing IDLE cycle and every REQ cycle
    always_comb begin
        stall_req_s = 1'b0;
        issue_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_op_s && !fault_s) begin
                    stall_req_s = 1'b1;
                    issue_s     = 1'b1;
                end else begin
                    stall_req_s = 1'b0;
                    issue_s     = 1'b0;
                end
            end
            ST_REQ:  stall_req_s = 1'b1;
            ST_DONE: stall_req_s = 1'b0;
            default: stall_req_s = 1'b0;
        endcase
    end

    // Memory bus request registers and load-data capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0000_0000;
            sel_q   <= 4'b0000;
            wdata_q <= 32'h0000_0000;
            op_q    <= 8'h00;
            lo_q    <= 2'b00;
            load_q  <= 32'h0000_0000;
        end else if (issue_s) begin
            req_q   <= 1'b1;
            we_q    <= is_store(mem_aluop_i);
            addr_q  <= {mem_mem_addr_i[31:2], 2'b00};
            sel_q   <= lane_sel(mem_aluop_i, mem_mem_addr_i[1:0]);
            wdata_q <= store_data(mem_aluop_i, mem_reg2_i);
            op_q    <= mem_aluop_i;
            lo_q    <= mem_mem_addr_i[1:0];
        end else if ((state_q == ST_REQ) && dm.ack) begin
            req_q <= 1'b0;
            if (!we_q) begin
                load_q <= load_extract(op_q, lo_q, dm.rdata);
            end
        end
    end

    // Write-back registers; a stalled edge always inserts a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_wd_q    <= 5'd0;
            wb_wreg_q  <= 1'b0;
            wb_wdata_q <= 32'h0000_0000;
            wb_pc_q    <= 32'h0000_0000;
        end else if (stall_req_s) begin
            wb_wreg_q <= 1'b0;
        end else if (state_q == ST_DONE) begin
            wb_wd_q    <= mem_wd_i;
            wb_wreg_q  <= mem_wreg_i;
            wb_wdata_q <= load_q;
            wb_pc_q    <= mem_pc_i;
        end else begin
            wb_wd_q    <= mem_wd_i;
            wb_wreg_q  <= mem_wreg_i & ~fault_s;
            wb_wdata_q <= mem_wdata_i;
            wb_pc_q    <= mem_pc_i;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic        misalign_q;
    logic [31:0] badvaddr_q;

    // Misalignment flag is re-evaluated for each instruction presented in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
            badvaddr_q <= 32'h0000_0000;
        end else if (state_q == ST_IDLE) begin
            if (fault_s) begin
                misalign_q <= 1'b1;
                badvaddr_q <= mem_mem_addr_i;
            end else begin
                misalign_q <= 1'b0;
            end
        end
    end

    assign misalign_exc_o = misalign_q;
    assign badvaddr_o     = badvaddr_q;
`else
    assign misalign_exc_o = 1'b0;
    assign badvaddr_o     = 32'h0000_0000;
`endif

    // Stall must read 0 while reset is asserted even though the inputs may hold a memory op
    assign stall_req_o = stall_req_s & rst_n;
    assign dm.req      = req_q;
    assign dm.we       = we_q;
    assign dm.addr     = addr_q;
    assign dm.sel      = sel_q;
    assign dm.wdata    = wdata_q;
    assign wb_wd_o     = wb_wd_q;
    assign wb_wreg_o   = wb_wreg_q;
    assign wb_wdata_o  = wb_wdata_q;
    assign wb_pc_o     = wb_pc_q;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized scoreboard bench for mem_stage: driver + reference model, memory responder, WB monitor.
module tb_mem_stage;

    localparam logic [7:0] OP_LB  = 8'hE0;
    localparam logic [7:0] OP_LH  = 8'hE1;
    localparam logic [7:0] OP_LW  = 8'hE3;
    localparam logic [7:0] OP_LBU = 8'hE4;
    localparam logic [7:0] OP_LHU = 8'hE5;
    localparam logic [7:0] OP_SB  = 8'hE8;
    localparam logic [7:0] OP_SH  = 8'hE9;
    localparam logic [7:0] OP_SW  = 8'hEB;
    localparam logic [7:0] OP_ADD = 8'h20;
    localparam logic [7:0] OP_OR  = 8'h25;

    typedef struct {
        logic [7:0]  op;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic [31:0] addr;
        logic [31:0] reg2;
        logic [31:0] pc;
        int          dly;
    } ins_t;

    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic [31:0] pc;
        logic        mis;
        logic [31:0] bad;
        bit          chk_fields;
        bit          chk_data;
        int          stalls;
    } wb_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
    } rq_t;

    logic        clk;
    logic        rst_n;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_mem_addr;
    logic [31:0] mem_reg2;
    logic [31:0] mem_pc;
    logic        stall_req;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic [31:0] wb_pc;
    logic        misalign_exc;
    logic [31:0] badvaddr;

    mem_stage_if dm();

    mem_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_wd_i       (mem_wd),
        .mem_wreg_i     (mem_wreg),
        .mem_wdata_i    (mem_wdata),
        .mem_aluop_i    (mem_aluop),
        .mem_mem_addr_i (mem_mem_addr),
        .mem_reg2_i     (mem_reg2),
        .mem_pc_i       (mem_pc),
        .dm             (dm.master),
        .stall_req_o    (stall_req),
        .wb_wd_o        (wb_wd),
        .wb_wreg_o      (wb_wreg),
        .wb_wdata_o     (wb_wdata),
        .wb_pc_o        (wb_pc),
        .misalign_exc_o (misalign_exc),
        .badvaddr_o     (badvaddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    wb_t         exp_q[$];
    rq_t         req_q[$];
    int          dly_q[$];
    logic [31:0] mem_w [0:255];
    logic [31:0] pc_ctr = 32'h0000_1000;
    int          nreq = 0;
    int          exp_nreq = 0;
    logic        m_mis = 1'b0;
    logic [31:0] m_bad = 32'h0;
    bit          mon_en = 1'b0;
    bit          mon_prev = 1'b0;
    logic        prev_stall = 1'b0;
    int          stall_cnt = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic bit is_load(input logic [7:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction

    function automatic bit is_store(input logic [7:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic ins_t mk(input logic [7:0] op, input logic [4:0] wd, input logic wreg,
                                input logic [31:0] wdata, input logic [31:0] addr,
                                input logic [31:0] reg2, input int dly);
        ins_t i;
        i.op = op; i.wd = wd; i.wreg = wreg; i.wdata = wdata;
        i.addr = addr; i.reg2 = reg2; i.dly = dly; i.pc = pc_ctr;
        pc_ctr = pc_ctr + 32'd4;
        return i;
    endfunction

    task automatic drive(input ins_t i);
        mem_aluop    = i.op;
        mem_wd       = i.wd;
        mem_wreg     = i.wreg;
        mem_wdata    = i.wdata;
        mem_mem_addr = i.addr;
        mem_reg2     = i.reg2;
        mem_pc       = i.pc;
    endtask

    // Reference model: expected request and WB result from the ISA rules, then hold until accepted
    task automatic issue(input ins_t i);
        wb_t         e;
        rq_t         r;
        bit          fault;
        bit          s;
        bit          done;
        int          off;
        logic [31:0] w;
        logic [31:0] b;
        logic [31:0] h;
        off = int'(i.addr % 32'd4);
`ifdef MEM_ALIGN_CHECK_EN
        fault = (i.op inside {OP_LH, OP_LHU, OP_SH} && (off % 2) != 0) ||
                (i.op inside {OP_LW, OP_SW} && off != 0);
`else
        fault = 1'b0;
`endif
        w = mem_w[(i.addr / 32'd4) % 32'd256];
        b = (w >> (8 * off)) % 32'd256;
        h = (w >> (16 * (off / 2))) % 32'd65536;
        e.wd = i.wd; e.pc = i.pc; e.wdata = i.wdata; e.wreg = i.wreg;
        e.chk_fields = 1'b1; e.chk_data = 1'b1; e.stalls = 0;
        if (fault) begin
            e.wreg = 1'b0; e.chk_fields = 1'b0; e.chk_data = 1'b0;
            m_mis = 1'b1; m_bad = i.addr;
        end else begin
            m_mis = 1'b0;
        end
        if (!fault && (is_load(i.op) || is_store(i.op))) begin
            e.stalls = 2 + i.dly;
            r.we = is_store(i.op);
            r.addr = i.addr - (i.addr % 32'd4);
            if (i.op inside {OP_LB, OP_LBU, OP_SB})      r.sel = 4'(1 << off);
            else if (i.op inside {OP_LH, OP_LHU, OP_SH}) r.sel = (off >= 2) ? 4'b1100 : 4'b0011;
            else                                         r.sel = 4'b1111;
            if (i.op == OP_SB)      r.wdata = (i.reg2 % 32'd256) * 32'h0101_0101;
            else if (i.op == OP_SH) r.wdata = (i.reg2 % 32'd65536) * 32'h0001_0001;
            else                    r.wdata = i.reg2;
            case (i.op)
                OP_LB:   e.wdata = (b >= 32'd128) ? b - 32'd256 : b;
                OP_LBU:  e.wdata = b;
                OP_LH:   e.wdata = (h >= 32'd32768) ? h - 32'd65536 : h;
                OP_LHU:  e.wdata = h;
                OP_LW:   e.wdata = w;
                default: e.chk_data = 1'b0;
            endcase
            req_q.push_back(r);
            dly_q.push_back(i.dly);
            exp_nreq++;
        end
        e.mis = m_mis; e.bad = m_bad;
        exp_q.push_back(e);
        drive(i);
        done = 1'b0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            s = stall_req;
            @(posedge clk);
            #1;
            if (!s) begin
                done = 1'b1;
                break;
            end
        end
        chk("issue_timeout", 32'(done), 32'd1);
    endtask

    // Data memory: checks each new request, holds ack off for the scheduled delay, random ack when idle
    int  rsp_wait = 0;
    bit  rsp_busy = 1'b0;
    rq_t snap;
    rq_t rq;
    always @(negedge clk) begin
        if (!rst_n) begin
            rsp_busy = 1'b0;
            dm.ack   = 1'b0;
        end else begin
            if (dm.req && !rsp_busy) begin
                nreq++;
                if (req_q.size() == 0) begin
                    chk("unexpected_req", 32'd1, 32'd0);
                end else begin
                    rq = req_q.pop_front();
                    chk("dm_we", 32'(dm.we), 32'(rq.we));
                    chk("dm_addr", dm.addr, rq.addr);
                    chk("dm_sel", 32'(dm.sel), 32'(rq.sel));
                    if (rq.we) chk("dm_wdata", dm.wdata, rq.wdata);
                end
                rsp_wait = (dly_q.size() != 0) ? dly_q.pop_front() : 0;
                snap.we = dm.we; snap.addr = dm.addr; snap.sel = dm.sel; snap.wdata = dm.wdata;
                rsp_busy = 1'b1;
            end else if (rsp_busy) begin
                chk("dm_stable", 32'(dm.req && dm.we == snap.we && dm.addr == snap.addr &&
                                    dm.sel == snap.sel && dm.wdata == snap.wdata), 32'd1);
            end
            if (rsp_busy) begin
                if (rsp_wait == 0) begin
                    dm.ack   = 1'b1;
                    dm.rdata = mem_w[dm.addr[9:2]];
                    rsp_busy = 1'b0;
                end else begin
                    dm.ack   = 1'b0;
                    dm.rdata = $urandom;
                    rsp_wait--;
                end
            end else begin
                dm.ack   = ($urandom_range(0, 3) == 0);
                dm.rdata = $urandom;
            end
        end
    end

    // WB monitor: a stalled edge must be a bubble, an unstalled edge retires the oldest expected result
    wb_t me;
    always @(negedge clk) begin
        if (mon_en && mon_prev) begin
            if (prev_stall) begin
                chk("bubble_wreg", 32'(wb_wreg), 32'd0);
                stall_cnt++;
            end else if (exp_q.size() == 0) begin
                chk("unexpected_wb", 32'd1, 32'd0);
            end else begin
                me = exp_q.pop_front();
                chk("wb_wreg", 32'(wb_wreg), 32'(me.wreg));
                if (me.chk_fields) begin
                    chk("wb_wd", 32'(wb_wd), 32'(me.wd));
                    chk("wb_pc", wb_pc, me.pc);
                end
                if (me.chk_data) chk("wb_wdata", wb_wdata, me.wdata);
                chk("stall_cycles", 32'(stall_cnt), 32'(me.stalls));
                chk("misalign_exc", 32'(misalign_exc), 32'(me.mis));
                chk("badvaddr", badvaddr, me.bad);
                stall_cnt = 0;
            end
        end else begin
            stall_cnt = 0;
        end
        mon_prev   = mon_en;
        prev_stall = stall_req;
    end

    logic [7:0] ops [0:9];
    ins_t       ri;
    bit         got;

    initial begin
        ops[0] = OP_LB; ops[1] = OP_LH; ops[2] = OP_LW; ops[3] = OP_LBU; ops[4] = OP_LHU;
        ops[5] = OP_SB; ops[6] = OP_SH; ops[7] = OP_SW; ops[8] = OP_ADD; ops[9] = OP_OR;
        for (int k = 0; k < 256; k++) mem_w[k] = $urandom;
        rst_n = 1'b0;
        dm.ack = 1'b0;
        dm.rdata = 32'h0;
        drive(mk(OP_ADD, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 0));
        #1;
        chk("rst_dm_req", 32'(dm.req), 32'd0);
        chk("rst_dm_sel", 32'(dm.sel), 32'd0);
        chk("rst_dm_addr", dm.addr, 32'd0);
        chk("rst_stall", 32'(stall_req), 32'd0);
        chk("rst_wb_wreg", 32'(wb_wreg), 32'd0);
        chk("rst_wb_wdata", wb_wdata, 32'd0);
        chk("rst_wb_pc", wb_pc, 32'd0);
        chk("rst_misalign", 32'(misalign_exc), 32'd0);
        chk("rst_badvaddr", badvaddr, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        issue(mk(OP_ADD, 5'd5, 1'b1, 32'h0000_1234, 32'h0, 32'h0, 0));
        mem_w[8'h40] = 32'h80FF_FFFF;
        issue(mk(OP_LB,  5'd7, 1'b1, $urandom, 32'h0000_0103, 32'h0, 0));
        issue(mk(OP_LBU, 5'd8, 1'b1, $urandom, 32'h0000_0103, 32'h0, 0));
        issue(mk(OP_SH,  5'd0, 1'b0, $urandom, 32'h0000_0202, 32'hAABB_CCDD, 3));
        mem_w[0] = 32'h0000_0011;
        mem_w[1] = 32'h0000_0022;
        issue(mk(OP_LW,  5'd9,  1'b1, $urandom, 32'h0000_0000, 32'h0, 0));
        issue(mk(OP_LW,  5'd10, 1'b1, $urandom, 32'h0000_0004, 32'h0, 0));
        issue(mk(OP_LW,  5'd11, 1'b1, $urandom, 32'h0000_0301, 32'h0, 1));
        issue(mk(OP_ADD, 5'd12, 1'b1, $urandom, 32'h0, 32'h0, 0));
        for (int n = 0; n < 160; n++) begin
            issue(mk(ops[$urandom_range(0, 9)], 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                     $urandom, 32'($urandom_range(0, 1023)), $urandom, $urandom_range(0, 3)));
        end
        issue(mk(OP_ADD, 5'd1, 1'b0, 32'h0, 32'h0, 32'h0, 0));
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        // Reset while a load waits for ack
        rq.we = 1'b0; rq.addr = 32'h0; rq.sel = 4'b1111; rq.wdata = 32'h0;
        req_q.push_back(rq);
        dly_q.push_back(50);
        exp_nreq++;
        drive(mk(OP_LW, 5'd3, 1'b1, 32'h0, 32'h0, 32'h0, 50));
        got = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (dm.req) begin
                got = 1'b1;
                break;
            end
        end
        chk("req_seen", 32'(got), 32'd1);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_dm_req", 32'(dm.req), 32'd0);
        chk("mid_rst_stall", 32'(stall_req), 32'd0);
        chk("mid_rst_wb_wreg", 32'(wb_wreg), 32'd0);
        chk("mid_rst_wb_wd", 32'(wb_wd), 32'd0);
        chk("mid_rst_wb_wdata", wb_wdata, 32'd0);
        drive(mk(OP_ADD, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 0));
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        issue(mk(OP_LW,  5'd4, 1'b1, $urandom, 32'h0000_0008, 32'h0, 1));
        issue(mk(OP_ADD, 5'd2, 1'b0, 32'h0, 32'h0, 32'h0, 0));
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        chk("final_drained", 32'(exp_q.size()), 32'd0);
        chk("request_count", 32'(nreq), 32'(exp_nreq));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
